apb_arb: RTL and testbench
==========================

Name: apb_arb

Overview:
- Round-robin arbiter that shares one APB4 bus between MASTERS APB4 masters.
- The shared bus feeds apb_mux, which decodes it into the slave PSELs.
- The block sequences the shared bus through a proper SETUP/ACCESS cycle for the granted master and holds every other master in wait (PREADY low).
- Address and control are registered at grant, so the shared bus is glitch-free and independent of master behaviour after grant.

Parameters:
MASTERS, 4, number of requesting APB masters (>=2)
PADDR_SIZE, 32, address width
PDATA_SIZE, 32, data width (multiple of 8)

Ports:
PCLK  input  1  clock; all logic on rising edge
PRESETn  input  1  reset, synchronous, active-low
MST_PSEL  input  1 [MASTERS]  per-master request/select
MST_PENABLE  input  1 [MASTERS]  per-master enable (ignored for arbitration)
MST_PADDR  input  PADDR_SIZE [MASTERS]  per-master address
MST_PWRITE  input  1 [MASTERS]  per-master direction
MST_PWDATA  input  PDATA_SIZE [MASTERS]  per-master write data
MST_PSTRB  input  PDATA_SIZE/8 [MASTERS]  per-master byte strobes
MST_PPROT  input  3 [MASTERS]  per-master protection
MST_PRDATA  output  PDATA_SIZE [MASTERS]  read data to each master
MST_PREADY  output  1 [MASTERS]  ready to each master
MST_PSLVERR  output  1 [MASTERS]  error to each master
SLV_PSEL  output  1  shared-bus select (to apb_mux MST_PSEL)
SLV_PENABLE  output  1  shared-bus enable
SLV_PADDR  output  PADDR_SIZE  shared-bus address
SLV_PWRITE  output  1  shared-bus direction
SLV_PWDATA  output  PDATA_SIZE  shared-bus write data
SLV_PSTRB  output  PDATA_SIZE/8  shared-bus strobes
SLV_PPROT  output  3  shared-bus protection
SLV_PRDATA  input  PDATA_SIZE  shared-bus read data (from apb_mux)
SLV_PREADY  input  1  shared-bus ready
SLV_PSLVERR  input  1  shared-bus error
GNT  output  $clog2(MASTERS)  index of the currently/last granted master (debug)

Behaviour:
- FSM states: IDLE, SETUP, ACCESS.
- Reset (PRESETn=0 at a PCLK edge):
  - state=IDLE; SLV_PSEL, SLV_PENABLE, SLV_PADDR, SLV_PWRITE, SLV_PWDATA, SLV_PSTRB, SLV_PPROT all 0.
  - GNT=0; round-robin pointer last=MASTERS-1, so master 0 has top priority first.
  - Reset mid-transfer aborts it; the shared bus is 0 on the next cycle.
- Arbitration is evaluated in IDLE, and in ACCESS on the completion cycle (SLV_PREADY=1).
  - Winner = first m with MST_PSEL[m]=1, searching last+1, last+2, ... modulo MASTERS.
  - In the completion cycle the just-served master is excluded, because its PSEL is still legally high.
- Grant edge:
  - Register winner's PADDR/PWRITE/PWDATA/PSTRB/PPROT onto the SLV_* outputs.
  - GNT=winner; last=winner; SLV_PSEL=1, SLV_PENABLE=0; state=SETUP.
- SETUP lasts exactly one cycle, then state=ACCESS with SLV_PENABLE=1.
- ACCESS, SLV_PREADY=0: hold all SLV_* outputs and wait. There is no timeout.
- ACCESS, SLV_PREADY=1: transfer completes this cycle.
  - Combinationally, MST_PREADY[GNT]=1, MST_PRDATA[GNT]=SLV_PRDATA, MST_PSLVERR[GNT]=SLV_PSLVERR.
  - Next state is SETUP if another request is pending (back-to-back, no idle cycle between transfers).
  - Otherwise next state is IDLE with SLV_PSEL=0 and SLV_PENABLE=0.
- Non-granted masters, and all masters outside the completion cycle: MST_PREADY=0, MST_PRDATA=0, MST_PSLVERR=0.
- Latency: master PSEL rising in IDLE at cycle 0 → shared SETUP at cycle 1 → ACCESS at cycle 2 → earliest MST_PREADY at cycle 2 (zero-wait-state slave).
- A master that drops PSEL before being granted is simply not served.
- A master that drops PSEL after grant does not abort the transfer; the captured transfer completes and its response is discarded.
- Simultaneous requests from all masters are served in strict rotation. Each master waits at most MASTERS-1 transfers.

Test Plan:
- Single master: MASTERS=4, master 2 writes PADDR=0x40, PWDATA=0xA5A5A5A5; slave PREADY=1 immediately → SLV_PSEL at cycle 1, SLV_PENABLE at cycle 2; MST_PREADY[2]=1 at cycle 2; GNT=2; then IDLE.
- Reset priority: after reset, masters 0 and 3 request at the same cycle → master 0 is granted first, then master 3 in back-to-back SETUP with no idle cycle.
- Round-robin fairness: all 4 masters request continuously → grant order 0,1,2,3,0; each MST_PREADY pulses once per 4 transfers.
- Wait states and error: slave holds PREADY=0 for 3 ACCESS cycles, then PREADY=1 with PSLVERR=1 and PRDATA=0x12345678 → SLV_* outputs stable throughout; MST_PSLVERR[g]=1 and MST_PRDATA[g]=0x12345678 only on the completion cycle; other masters see 0.
- Isolation: master 1 changes MST_PADDR during its ACCESS → SLV_PADDR holds the value captured at grant.
- Mid-transfer reset: PRESETn=0 during ACCESS → next cycle SLV_PSEL=0, SLV_PENABLE=0, all MST_PREADY=0; after release master 0 has priority again.

Source files
------------

// File: rtl/apb_arb.sv
// apb_arb: round-robin arbiter sharing one APB4 bus between MASTERS masters.
// The granted master's address/control/data are captured at grant, and the
// shared bus is driven through a SETUP/ACCESS pair. Every other master sees
// PREADY low until its own completion cycle.
module apb_arb #(
  parameter int MASTERS    = 4,
  parameter int PADDR_SIZE = 32,
  parameter int PDATA_SIZE = 32
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic [MASTERS-1:0]           MST_PSEL,
  input  logic [MASTERS-1:0]           MST_PENABLE,
  input  logic [PADDR_SIZE-1:0]        MST_PADDR   [MASTERS],
  input  logic [MASTERS-1:0]           MST_PWRITE,
  input  logic [PDATA_SIZE-1:0]        MST_PWDATA  [MASTERS],
  input  logic [PDATA_SIZE/8-1:0]      MST_PSTRB   [MASTERS],
  input  logic [2:0]                   MST_PPROT   [MASTERS],
  output logic [PDATA_SIZE-1:0]        MST_PRDATA  [MASTERS],
  output logic [MASTERS-1:0]           MST_PREADY,
  output logic [MASTERS-1:0]           MST_PSLVERR,
  output logic                         SLV_PSEL,
  output logic                         SLV_PENABLE,
  output logic [PADDR_SIZE-1:0]        SLV_PADDR,
  output logic                         SLV_PWRITE,
  output logic [PDATA_SIZE-1:0]        SLV_PWDATA,
  output logic [PDATA_SIZE/8-1:0]      SLV_PSTRB,
  output logic [2:0]                   SLV_PPROT,
  input  logic [PDATA_SIZE-1:0]        SLV_PRDATA,
  input  logic                         SLV_PREADY,
  input  logic                         SLV_PSLVERR,
  output logic [$clog2(MASTERS)-1:0]   GNT
);

  localparam int GW = $clog2(MASTERS);
  localparam int SW = PDATA_SIZE / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         gnt_q, gnt_d;
  logic [GW-1:0]         last_q, last_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [PADDR_SIZE-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [PDATA_SIZE-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0]         pstrb_q, pstrb_d;
  logic [2:0]            pprot_q, pprot_d;

  logic                  win_vld;
  logic [GW-1:0]         win_idx;
  logic [GW-1:0]         cand;
  logic                  excl;
  logic                  grant;

  // PENABLE from masters plays no part in arbitration.
  logic unused_penable;
  assign unused_penable = ^MST_PENABLE;

  // Rotating search starting after the last grant; in ACCESS the master
  // being served is skipped because its PSEL is still legally high.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    excl    = (state_q == ACCESS);
    for (int i = 1; i <= MASTERS; i++) begin
      cand = GW'((int'(last_q) + i) % MASTERS);
      if (!win_vld && MST_PSEL[cand] && !(excl && (cand == gnt_q))) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next-state and shared-bus register updates.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pprot_d   = pprot_q;
    grant     = 1'b0;
    case (state_q)
      IDLE: grant = win_vld;
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (SLV_PREADY) begin
          if (win_vld) begin
            grant = 1'b1;
          end else begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      state_d   = SETUP;
      gnt_d     = win_idx;
      last_d    = win_idx;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      paddr_d   = MST_PADDR[win_idx];
      pwrite_d  = MST_PWRITE[win_idx];
      pwdata_d  = MST_PWDATA[win_idx];
      pstrb_d   = MST_PSTRB[win_idx];
      pprot_d   = MST_PPROT[win_idx];
    end
  end

  // State and shared-bus registers; reset leaves master 0 with top priority.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      last_q    <= GW'(MASTERS - 1);
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      pprot_q   <= pprot_d;
    end
  end

  // Route the slave response to the granted master on the completion cycle only.
  always_comb begin
    MST_PREADY  = '0;
    MST_PSLVERR = '0;
    for (int m = 0; m < MASTERS; m++) begin
      MST_PRDATA[m] = '0;
      if ((state_q == ACCESS) && SLV_PREADY && (gnt_q == GW'(m))) begin
        MST_PREADY[m]  = 1'b1;
        MST_PSLVERR[m] = SLV_PSLVERR;
        MST_PRDATA[m]  = SLV_PRDATA;
      end
    end
  end

  assign SLV_PSEL    = psel_q;
  assign SLV_PENABLE = penable_q;
  assign SLV_PADDR   = paddr_q;
  assign SLV_PWRITE  = pwrite_q;
  assign SLV_PWDATA  = pwdata_q;
  assign SLV_PSTRB   = pstrb_q;
  assign SLV_PPROT   = pprot_q;
  assign GNT         = gnt_q;

endmodule

// File: tb/tb_apb_arb.sv
// tb_apb_arb: directed cycle table, hand-written corner sequences and a
// randomized run against a transfer-level reference model.
module tb_apb_arb;
  localparam int N = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [3:0]  mst_psel, mst_penable, mst_pwrite;
  logic [31:0] mst_paddr  [N];
  logic [31:0] mst_pwdata [N];
  logic [3:0]  mst_pstrb  [N];
  logic [2:0]  mst_pprot  [N];
  logic [31:0] mst_prdata [N];
  logic [3:0]  mst_pready, mst_pslverr;
  logic        slv_psel, slv_penable, slv_pwrite;
  logic [31:0] slv_paddr, slv_pwdata, slv_prdata;
  logic [3:0]  slv_pstrb;
  logic [2:0]  slv_pprot;
  logic        slv_pready, slv_pslverr;
  logic [1:0]  gnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 PCLK = ~PCLK;

  apb_arb #(.MASTERS(N), .PADDR_SIZE(32), .PDATA_SIZE(32)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .MST_PSEL(mst_psel), .MST_PENABLE(mst_penable), .MST_PADDR(mst_paddr),
    .MST_PWRITE(mst_pwrite), .MST_PWDATA(mst_pwdata), .MST_PSTRB(mst_pstrb),
    .MST_PPROT(mst_pprot), .MST_PRDATA(mst_prdata), .MST_PREADY(mst_pready),
    .MST_PSLVERR(mst_pslverr),
    .SLV_PSEL(slv_psel), .SLV_PENABLE(slv_penable), .SLV_PADDR(slv_paddr),
    .SLV_PWRITE(slv_pwrite), .SLV_PWDATA(slv_pwdata), .SLV_PSTRB(slv_pstrb),
    .SLV_PPROT(slv_pprot), .SLV_PRDATA(slv_prdata), .SLV_PREADY(slv_pready),
    .SLV_PSLVERR(slv_pslverr), .GNT(gnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  function automatic logic [31:0] wd(input int m);
    return (m == 2) ? 32'hA5A5_A5A5 : (32'h5000_0000 | 32'(m));
  endfunction

  // ---------------- directed cycle table ----------------
  typedef struct {
    logic        rst_n;
    logic [3:0]  psel;
    logic        pready;
    logic        e_psel;
    logic        e_pen;
    logic [1:0]  e_gnt;
    logic [3:0]  e_rdy;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic r, input logic [3:0] ps, input logic pr,
                     input logic ep, input logic en, input logic [1:0] eg,
                     input logic [3:0] er, input logic [31:0] ea);
    vec_t v;
    v.rst_n = r; v.psel = ps; v.pready = pr; v.e_psel = ep; v.e_pen = en;
    v.e_gnt = eg; v.e_rdy = er; v.e_addr = ea;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  bit          m_busy, m_acc;
  int          m_cur, m_last;
  logic [31:0] m_addr, m_wdata;
  logic        m_write;
  logic [3:0]  m_strb;
  logic [2:0]  m_prot;

  // Winner = requester at smallest rotational distance after the last grant.
  function automatic int pick(input logic [3:0] req, input int last, input int excl);
    int best;
    int bd;
    int d;
    best = -1;
    bd   = N;
    for (int m = 0; m < N; m++) begin
      if (req[m] && m != excl) begin
        d = (m - last - 1 + 2 * N) % N;
        if (d < bd) begin
          bd   = d;
          best = m;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_cur = 0; m_last = N - 1;
    m_addr = '0; m_wdata = '0; m_write = 1'b0; m_strb = '0; m_prot = '0;
  endtask

  task automatic model_capture(input int w);
    m_busy = 1; m_acc = 0; m_cur = w; m_last = w;
    m_addr = mst_paddr[w]; m_wdata = mst_pwdata[w]; m_write = mst_pwrite[w];
    m_strb = mst_pstrb[w]; m_prot = mst_pprot[w];
  endtask

  task automatic model_edge();
    int w;
    if (!PRESETn) begin
      model_reset();
    end else if (!m_busy) begin
      w = pick(mst_psel, m_last, -1);
      if (w >= 0) model_capture(w);
    end else if (!m_acc) begin
      m_acc = 1;
    end else if (slv_pready) begin
      w = pick(mst_psel, m_last, m_cur);
      if (w >= 0) model_capture(w);
      else begin
        m_busy = 0;
        m_acc  = 0;
      end
    end
  endtask

  task automatic model_check();
    bit done;
    logic [31:0] ed;
    done = m_busy && m_acc && slv_pready;
    chk("rnd_psel", 64'(slv_psel), 64'(m_busy));
    chk("rnd_penable", 64'(slv_penable), 64'(m_acc));
    chk("rnd_gnt", 64'(gnt), 64'(m_cur));
    chk("rnd_paddr", 64'(slv_paddr), 64'(m_addr));
    chk("rnd_pwdata", 64'(slv_pwdata), 64'(m_wdata));
    chk("rnd_ctrl", 64'({slv_pwrite, slv_pstrb, slv_pprot}), 64'({m_write, m_strb, m_prot}));
    chk("rnd_pready", 64'(mst_pready), done ? 64'(1 << m_cur) : 64'(0));
    chk("rnd_pslverr", 64'(mst_pslverr), (done && slv_pslverr) ? 64'(1 << m_cur) : 64'(0));
    for (int m = 0; m < N; m++) begin
      ed = (done && m == m_cur) ? slv_prdata : 32'h0;
      chk("rnd_prdata", 64'(mst_prdata[m]), 64'(ed));
    end
  endtask

  initial begin
    logic [31:0] s_addr, s_wdata;
    logic [7:0]  s_ctrl;
    vec_t v;

    PRESETn = 1'b0; mst_psel = '0; mst_penable = '0; mst_pwrite = 4'hF;
    slv_pready = 1'b0; slv_pslverr = 1'b0; slv_prdata = '0;
    for (int m = 0; m < N; m++) begin
      mst_paddr[m] = 32'h10 << m; mst_pwdata[m] = wd(m);
      mst_pstrb[m] = 4'hF; mst_pprot[m] = 3'(m);
    end
    step(); step();

    // rst, psel, prdy | e_psel, e_pen, e_gnt, e_rdy, e_addr
    add(0, 4'b0000, 1, 0, 0, 2'd0, 4'b0000, 32'h00); // reset state
    add(1, 4'b0100, 1, 0, 0, 2'd0, 4'b0000, 32'h00); // master 2 requests
    add(1, 4'b0100, 1, 1, 0, 2'd2, 4'b0000, 32'h40); // SETUP
    add(1, 4'b0100, 1, 1, 1, 2'd2, 4'b0100, 32'h40); // ACCESS, done
    add(1, 4'b0000, 1, 0, 0, 2'd2, 4'b0000, 32'h40); // IDLE
    add(0, 4'b0000, 1, 0, 0, 2'd2, 4'b0000, 32'h40); // reset edge
    add(1, 4'b1001, 1, 0, 0, 2'd0, 4'b0000, 32'h00); // 0 and 3 request
    add(1, 4'b1001, 1, 1, 0, 2'd0, 4'b0000, 32'h10);
    add(1, 4'b1001, 1, 1, 1, 2'd0, 4'b0001, 32'h10);
    add(1, 4'b1000, 1, 1, 0, 2'd3, 4'b0000, 32'h80); // back-to-back SETUP
    add(1, 4'b1000, 1, 1, 1, 2'd3, 4'b1000, 32'h80);
    add(1, 4'b0000, 1, 0, 0, 2'd3, 4'b0000, 32'h80);
    add(1, 4'b1111, 1, 0, 0, 2'd3, 4'b0000, 32'h80); // all request
    add(1, 4'b1111, 1, 1, 0, 2'd0, 4'b0000, 32'h10);
    add(1, 4'b1111, 1, 1, 1, 2'd0, 4'b0001, 32'h10);
    add(1, 4'b1111, 1, 1, 0, 2'd1, 4'b0000, 32'h20);
    add(1, 4'b1111, 1, 1, 1, 2'd1, 4'b0010, 32'h20);
    add(1, 4'b1111, 1, 1, 0, 2'd2, 4'b0000, 32'h40);
    add(1, 4'b1111, 1, 1, 1, 2'd2, 4'b0100, 32'h40);
    add(1, 4'b1111, 1, 1, 0, 2'd3, 4'b0000, 32'h80);
    add(1, 4'b1111, 1, 1, 1, 2'd3, 4'b1000, 32'h80);
    add(1, 4'b1111, 1, 1, 0, 2'd0, 4'b0000, 32'h10);
    add(1, 4'b1111, 1, 1, 1, 2'd0, 4'b0001, 32'h10);
    add(1, 4'b0000, 1, 1, 0, 2'd1, 4'b0000, 32'h20); // 1 dropped PSEL after grant
    add(1, 4'b0000, 1, 1, 1, 2'd1, 4'b0010, 32'h20); // still completes
    add(1, 4'b0000, 1, 0, 0, 2'd1, 4'b0000, 32'h20);

    slv_prdata = 32'hCAFE_0000;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      PRESETn = v.rst_n; mst_psel = v.psel; slv_pready = v.pready;
      #1;
      chk("tbl_psel", 64'(slv_psel), 64'(v.e_psel));
      chk("tbl_penable", 64'(slv_penable), 64'(v.e_pen));
      chk("tbl_gnt", 64'(gnt), 64'(v.e_gnt));
      chk("tbl_pready", 64'(mst_pready), 64'(v.e_rdy));
      chk("tbl_paddr", 64'(slv_paddr), 64'(v.e_addr));
      if (v.e_psel) chk("tbl_pwdata", 64'(slv_pwdata), 64'(wd(int'(v.e_gnt))));
      for (int m = 0; m < N; m++)
        chk("tbl_prdata", 64'(mst_prdata[m]), v.e_rdy[m] ? 64'h0000_0000_CAFE_0000 : 64'h0);
      step();
    end

    // Wait states then error completion for master 3.
    mst_psel = 4'b1000; slv_pready = 1'b0; slv_pslverr = 1'b1; slv_prdata = 32'h1234_5678;
    step();
    #1;
    chk("ws_setup", 64'({slv_psel, slv_penable}), 64'(2'b10));
    chk("ws_gnt", 64'(gnt), 64'(3));
    chk("ws_paddr", 64'(slv_paddr), 64'(32'h80));
    chk("ws_pwdata", 64'(slv_pwdata), 64'(wd(3)));
    chk("ws_ctrl", 64'({slv_pwrite, slv_pstrb, slv_pprot}), 64'({1'b1, 4'hF, 3'd3}));
    s_addr = slv_paddr; s_wdata = slv_pwdata; s_ctrl = {slv_pwrite, slv_pstrb, slv_pprot};
    step();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("ws_wait_bus", 64'({slv_psel, slv_penable}), 64'(2'b11));
      chk("ws_wait_paddr", 64'(slv_paddr), 64'(s_addr));
      chk("ws_wait_pwdata", 64'(slv_pwdata), 64'(s_wdata));
      chk("ws_wait_ctrl", 64'({slv_pwrite, slv_pstrb, slv_pprot}), 64'(s_ctrl));
      chk("ws_wait_pready", 64'(mst_pready), 64'(0));
      chk("ws_wait_pslverr", 64'(mst_pslverr), 64'(0));
      chk("ws_wait_prdata3", 64'(mst_prdata[3]), 64'(0));
      step();
    end
    slv_pready = 1'b1;
    #1;
    chk("ws_done_pready", 64'(mst_pready), 64'(4'b1000));
    chk("ws_done_pslverr", 64'(mst_pslverr), 64'(4'b1000));
    chk("ws_done_prdata3", 64'(mst_prdata[3]), 64'(32'h1234_5678));
    chk("ws_done_prdata0", 64'(mst_prdata[0]), 64'(0));
    chk("ws_done_paddr", 64'(slv_paddr), 64'(s_addr));
    mst_psel = 4'b0000;
    step();
    #1;
    chk("ws_idle_bus", 64'({slv_psel, slv_penable}), 64'(2'b00));
    chk("ws_idle_pready", 64'(mst_pready), 64'(0));
    chk("ws_idle_pslverr", 64'(mst_pslverr), 64'(0));
    chk("ws_idle_prdata3", 64'(mst_prdata[3]), 64'(0));

    // Isolation: master 1 changes its address during ACCESS.
    slv_pready = 1'b0; slv_pslverr = 1'b0; mst_psel = 4'b0010;
    step();
    #1;
    chk("iso_gnt", 64'(gnt), 64'(1));
    chk("iso_paddr_setup", 64'(slv_paddr), 64'(32'h20));
    step();
    mst_paddr[1] = 32'hDEAD_0000;
    #1;
    chk("iso_paddr_acc", 64'(slv_paddr), 64'(32'h20));
    step();
    #1;
    chk("iso_paddr_hold", 64'(slv_paddr), 64'(32'h20));
    chk("iso_penable", 64'(slv_penable), 64'(1));
    slv_pready = 1'b1;
    #1;
    chk("iso_pready", 64'(mst_pready), 64'(4'b0010));
    mst_psel = 4'b0000;
    step();
    mst_paddr[1] = 32'h20;

    // Reset in the middle of an ACCESS for master 2.
    slv_pready = 1'b0; mst_psel = 4'b0100;
    step();
    step();
    #1;
    chk("mrst_access", 64'({slv_psel, slv_penable, gnt}), 64'({2'b11, 2'd2}));
    PRESETn = 1'b0;
    step();
    PRESETn = 1'b1; slv_pready = 1'b1; mst_psel = 4'b1001;
    #1;
    chk("mrst_bus", 64'({slv_psel, slv_penable}), 64'(2'b00));
    chk("mrst_pready", 64'(mst_pready), 64'(0));
    chk("mrst_gnt", 64'(gnt), 64'(0));
    chk("mrst_paddr", 64'(slv_paddr), 64'(0));
    step();
    #1;
    chk("mrst_prio_gnt", 64'(gnt), 64'(0));
    chk("mrst_prio_bus", 64'({slv_psel, slv_penable}), 64'(2'b10));
    chk("mrst_prio_paddr", 64'(slv_paddr), 64'(32'h10));

    // Randomized run against the reference model.
    PRESETn = 1'b0; mst_psel = '0;
    step(); step();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      PRESETn = ($urandom_range(0, 299) != 0);
      for (int m = 0; m < N; m++) begin
        if ($urandom_range(0, 3) == 0) mst_psel[m] = ~mst_psel[m];
        mst_paddr[m]  = $urandom;
        mst_pwdata[m] = $urandom;
        mst_pstrb[m]  = 4'($urandom);
        mst_pprot[m]  = 3'($urandom);
      end
      mst_pwrite  = 4'($urandom);
      mst_penable = 4'($urandom);
      slv_pready  = 1'($urandom);
      slv_pslverr = 1'($urandom);
      slv_prdata  = $urandom;
      #1;
      model_check();
      model_edge();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
